// File: rtl/mux4_rr_sched.sv
// Round-robin grant scheduler for a 4-to-1 mux.
// Bounded bursts, registered one-hot grant and select.
module mux4_rr_sched #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [3:0] MB = 4'(MAX_BURST);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;

  logic [1:0] own;
  logic       rel;
  logic [1:0] base;
  logic       hit;
  logic [1:0] win;

  assign own  = {s1, s0};
  assign rel  = (state == BUSY) &&
                (!req[own] || cnt == MB);
  // A releasing owner drops to lowest priority immediately.
  assign base = rel ? own + 2'd1 : ptr;

  // First asserted request at or after base wins.
  always_comb begin
    hit = 1'b0;
    win = base;
    for (int i = 3; i >= 0; i--) begin
      if (req[base + 2'(i)]) begin
        hit = 1'b1;
        win = base + 2'(i);
      end
    end
  end

  // Grant FSM; all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      s1    <= 1'b0;
      s0    <= 1'b0;
      busy  <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state     <= BUSY;
            gnt       <= 4'b0001 << win;
            {s1, s0}  <= win;
            cnt       <= 4'd1;
            busy      <= 1'b1;
          end
        end
        BUSY: begin
          if (!rel) begin
            cnt <= cnt + 4'd1;
          end else begin
            ptr <= own + 2'd1;
            if (hit) begin
              gnt      <= 4'b0001 << win;
              {s1, s0} <= win;
              cnt      <= 4'd1;
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
              busy  <= 1'b0;
              cnt   <= 4'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed and random checks for mux4_rr_sched.
// Instance a uses MAX_BURST=4, instance b MAX_BURST=1.
module tb_mux4_rr_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] ga, gb;
  logic       s1a, s0a, s1b, s0b;
  logic       busya, busyb;

  int total = 0;
  int bad   = 0;

  int run [2];
  int wt  [2][4];
  logic [3:0] pg [2];

  always #5 clk = ~clk;

  mux4_rr_sched #(.MAX_BURST(4)) ua (
    .clk(clk), .reset(reset), .req(req),
    .gnt(ga), .s1(s1a), .s0(s0a), .busy(busya)
  );

  mux4_rr_sched #(.MAX_BURST(1)) ub (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gb), .s1(s1b), .s0(s0b), .busy(busyb)
  );

  task automatic chk(input string tag,
                     input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic inv(input int u,
                     input logic [3:0] g,
                     input logic [1:0] s,
                     input logic b,
                     input logic [3:0] rq,
                     input int mb);
    chk("onehot", int'($countones(g) <= 1), 1);
    chk("busy", int'(b), int'(g != 4'b0));
    if (b) chk("sel", int'(g[s]), 1);
    if (g != 4'b0 && g == pg[u]) begin
      if ((rq & ~g) != 4'b0) run[u]++;
      else run[u] = (run[u] >= mb) ? 1 : run[u] + 1;
    end else begin
      run[u] = (g != 4'b0) ? 1 : 0;
    end
    chk("burst", int'(run[u] <= mb), 1);
    for (int k = 0; k < 4; k++) begin
      if (rq[k] && !g[k]) wt[u][k]++;
      else wt[u][k] = 0;
      chk("starve", int'(wt[u][k] <= 3*mb+3), 1);
    end
    pg[u] = g;
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    chk("rst_gnt", ga, 0);
    chk("rst_sel", {s1a, s0a}, 0);
    chk("rst_busy", busya, 0);
    chk("rst_gnt_b", gb, 0);
    reset = 1'b0;
    tick();
    chk("idle_gnt", ga, 0);
    chk("idle_busy", busya, 0);

    // single requester held: continuous grant
    req = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("r25_gnt", ga, 4);
      chk("r25_sel", {s1a, s0a}, 2);
      chk("r25_busy", busya, 1);
    end

    // all requesting: 4-cycle bursts in order
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("r26_gnt", ga, 1 << ((i / 4) % 4));
    end

    // owner drops early, pointer advance
    do_reset();
    req = 4'b0001;
    tick();
    chk("r27_g0", ga, 1);
    req = 4'b1010;
    tick();
    chk("r27_gnt", ga, 2);
    chk("r27_sel", {s1a, s0a}, 1);
    req = 4'b0010;
    tick();
    chk("r21_hold", ga, 2);
    req = 4'b1010;
    tick();
    chk("r21_hold", ga, 2);
    tick();
    chk("r21_hold", ga, 2);
    tick();
    chk("r27_next", ga, 8);
    chk("r27_nsel", {s1a, s0a}, 3);

    // reset mid-burst
    req = 4'b1000;
    tick();
    chk("r29_pre", ga, 8);
    reset = 1'b1;
    tick();
    chk("r29_gnt", ga, 0);
    chk("r29_sel", {s1a, s0a}, 0);
    chk("r29_busy", busya, 0);
    reset = 1'b0;
    tick();
    chk("r29_regnt", ga, 8);
    chk("r29_resel", {s1a, s0a}, 3);

    // release to idle keeps last select
    req = 4'b0000;
    tick();
    chk("r17_gnt", ga, 0);
    chk("r17_busy", busya, 0);
    chk("r19_sel", {s1a, s0a}, 3);

    // MAX_BURST=1 alternation
    do_reset();
    req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("r28_gnt", gb, (i % 2 == 0) ? 1 : 8);
    end

    // random stimulus with invariant checks
    do_reset();
    for (int u = 0; u < 2; u++) begin
      run[u] = 0;
      pg[u]  = 4'b0;
      for (int k = 0; k < 4; k++) wt[u][k] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(7) == 0) req[k] = ~req[k];
      tick();
      inv(0, ga, {s1a, s0a}, busya, req, 4);
      inv(1, gb, {s1b, s0b}, busyb, req, 1);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
